decode_stage: RTL and testbench

- ID stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch.
- Consumes the fetch-to-decode bundle (instruction, pc_cur) and decodes the instruction.
- Reads operands from an internal 32x32 register file that is written by writeback.
- Registers the result into the decode-to-execute bundle, and detects load-use hazards so it can stall fetch.

---
 rtl/decode_stage_pkg.sv | 98 +++++++++
 rtl/decode_stage_if.sv | 20 ++
 rtl/decode_stage_register_file.sv | 55 +++++
 rtl/decode_stage.sv | 161 ++++++++++++++++
 tb/tb_decode_stage.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage.
package decode_stage_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NUM_REGS_DEF = 32;

   typedef logic [31:0] data_t;
   typedef logic [31:0] addr_t;
   typedef logic [4:0]  reg_idx_t;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_FENCE  = 7'b0001111
   } opcode_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2
   } result_src_t;

   typedef enum logic [1:0] {
      PC_SRC_PLUS4  = 2'd0,
      PC_SRC_BRANCH = 2'd1,
      PC_SRC_JAL    = 2'd2,
      PC_SRC_JALR   = 2'd3
   } pc_src_t;

   // Immediate formats
   localparam logic [2:0] IMM_FMT_NONE = 3'd0;
   localparam logic [2:0] IMM_FMT_I    = 3'd1;
   localparam logic [2:0] IMM_FMT_S    = 3'd2;
   localparam logic [2:0] IMM_FMT_B    = 3'd3;
   localparam logic [2:0] IMM_FMT_U    = 3'd4;
   localparam logic [2:0] IMM_FMT_J    = 3'd5;

   // ---- IF -> ID bundle -------------------------------------------------
   typedef struct packed {
      data_t instruction;
      addr_t pc_cur;
   } if_to_id_t;

   // ---- WB -> ID bundle -------------------------------------------------
   typedef struct packed {
      logic     reg_write;
      reg_idx_t rd;
      data_t    rd_data;
   } wb_to_id_t;

   // ---- ID -> EX bundle -------------------------------------------------
   typedef struct packed {
      logic        valid;
      logic        illegal;
      addr_t       pc_cur;
      data_t       rs1_data;
      data_t       rs2_data;
      data_t       imm_ext;
      reg_idx_t    rs1;
      reg_idx_t    rs2;
      reg_idx_t    rd;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic        alu_src_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        jalr;
      result_src_t result_src;
      pc_src_t     pc_src_hint;
   } id_to_ex_t;

   // Build the sign-extended immediate for the given format.
   function automatic data_t imm_gen(input data_t instr, input logic [2:0] fmt);
      data_t imm;
      case (fmt)
         IMM_FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
         IMM_FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         IMM_FMT_U: imm = {instr[31:12], 12'b0};
         IMM_FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         default:   imm = 32'h0000_0000;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle interface between fetch/writeback/execute and the decode stage.
interface decode_stage_if;
   import decode_stage_pkg::*;

   if_to_id_t IF_to_ID;
   wb_to_id_t WB_to_ID;
   logic      flush;
   id_to_ex_t ID_to_EX;
   logic      stall_if;

   modport master (
      output IF_to_ID, WB_to_ID, flush,
      input  ID_to_EX, stall_if
   );

   modport slave (
      input  IF_to_ID, WB_to_ID, flush,
      output ID_to_EX, stall_if
   );
endinterface

// File: rtl/decode_stage_register_file.sv
// Architectural register file: 2 async read ports, 1 sync write port,
// write-through bypass, x0 hardwired to zero.
module decode_stage_register_file #(
   parameter int NUM_REGS = 32,
   parameter int XLEN     = 32,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr_i,
   input  logic [AW-1:0]   rs2_addr_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   input  logic            we_i,
   input  logic [AW-1:0]   wr_addr_i,
   input  logic [XLEN-1:0] wr_data_i
);

   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic            wr_live;

   assign wr_live = we_i && (wr_addr_i != '0);

   // Storage update: clear all entries on reset, otherwise commit WB writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_live) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read ports with x0 forcing and same-cycle forwarding of the WB write.
   always_comb begin
      rs1_data_o = '0;
      rs2_data_o = '0;
      if (rs1_addr_i == '0) begin
         rs1_data_o = '0;
      end else if (wr_live && (wr_addr_i == rs1_addr_i)) begin
         rs1_data_o = wr_data_i;
      end else begin
         rs1_data_o = regs_q[rs1_addr_i];
      end
      if (rs2_addr_i == '0) begin
         rs2_data_o = '0;
      end else if (wr_live && (wr_addr_i == rs2_addr_i)) begin
         rs2_data_o = wr_data_i;
      end else begin
         rs2_data_o = regs_q[rs2_addr_i];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode stage: decode, operand read, load-use stall.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int XLEN     = 32
) (
   input  logic           clk,
   input  logic           reset,
   decode_stage_if.slave  bus
);

   data_t     instr;
   data_t     rf_rs1_data;
   data_t     rf_rs2_data;
   id_to_ex_t dec;
   id_to_ex_t id_to_ex_d;
   id_to_ex_t id_to_ex_q;
   logic [2:0] imm_fmt;
   logic      rs1_used;
   logic      rs2_used;
   logic      hazard;

   assign instr = bus.IF_to_ID.instruction;

   decode_stage_register_file #(
      .NUM_REGS (NUM_REGS),
      .XLEN     (XLEN)
   ) u_regfile (
      .clk        (clk),
      .reset      (reset),
      .rs1_addr_i (instr[19:15]),
      .rs2_addr_i (instr[24:20]),
      .rs1_data_o (rf_rs1_data),
      .rs2_data_o (rf_rs2_data),
      .we_i       (bus.WB_to_ID.reg_write),
      .wr_addr_i  (bus.WB_to_ID.rd),
      .wr_data_i  (bus.WB_to_ID.rd_data)
   );

   // Decode the instruction in ID into control bits, fields and immediate.
   always_comb begin
      dec          = '0;
      imm_fmt      = IMM_FMT_NONE;
      rs1_used     = 1'b0;
      rs2_used     = 1'b0;
      dec.valid    = 1'b1;
      dec.pc_cur   = bus.IF_to_ID.pc_cur;
      dec.rs1_data = rf_rs1_data;
      dec.rs2_data = rf_rs2_data;
      dec.rs1      = instr[19:15];
      dec.rs2      = instr[24:20];
      dec.rd       = instr[11:7];
      dec.funct3   = instr[14:12];
      dec.funct7b5 = instr[30];
      dec.result_src  = RES_ALU;
      dec.pc_src_hint = PC_SRC_PLUS4;
      if (instr[1:0] != 2'b11) begin
         dec.illegal = 1'b1;
      end else begin
         case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
               imm_fmt         = IMM_FMT_U;
               dec.reg_write   = 1'b1;
               dec.alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
               imm_fmt         = IMM_FMT_J;
               dec.reg_write   = 1'b1;
               dec.jump        = 1'b1;
               dec.result_src  = RES_PC4;
               dec.pc_src_hint = PC_SRC_JAL;
            end
            OPC_JALR: begin
               imm_fmt         = IMM_FMT_I;
               rs1_used        = 1'b1;
               dec.reg_write   = 1'b1;
               dec.jump        = 1'b1;
               dec.jalr        = 1'b1;
               dec.alu_src_imm = 1'b1;
               dec.result_src  = RES_PC4;
               dec.pc_src_hint = PC_SRC_JALR;
            end
            OPC_BRANCH: begin
               imm_fmt         = IMM_FMT_B;
               rs1_used        = 1'b1;
               rs2_used        = 1'b1;
               dec.branch      = 1'b1;
               dec.pc_src_hint = PC_SRC_BRANCH;
            end
            OPC_LOAD: begin
               imm_fmt         = IMM_FMT_I;
               rs1_used        = 1'b1;
               dec.reg_write   = 1'b1;
               dec.mem_read    = 1'b1;
               dec.alu_src_imm = 1'b1;
               dec.result_src  = RES_MEM;
            end
            OPC_STORE: begin
               imm_fmt         = IMM_FMT_S;
               rs1_used        = 1'b1;
               rs2_used        = 1'b1;
               dec.mem_write   = 1'b1;
               dec.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
               imm_fmt         = IMM_FMT_I;
               rs1_used        = 1'b1;
               dec.reg_write   = 1'b1;
               dec.alu_src_imm = 1'b1;
            end
            OPC_OP: begin
               rs1_used        = 1'b1;
               rs2_used        = 1'b1;
               dec.reg_write   = 1'b1;
            end
            OPC_FENCE: begin
               dec.illegal     = 1'b0;
            end
            default: begin
               dec.illegal     = 1'b1;
            end
         endcase
      end
      dec.imm_ext = imm_gen(instr, imm_fmt);
   end

   // Load-use hazard: load in EX whose rd feeds a used source of ID.
   always_comb begin
      hazard = 1'b0;
      if (id_to_ex_q.valid && id_to_ex_q.mem_read && (id_to_ex_q.rd != 5'd0)) begin
         hazard = (rs1_used && (id_to_ex_q.rd == dec.rs1)) ||
                  (rs2_used && (id_to_ex_q.rd == dec.rs2));
      end else begin
         hazard = 1'b0;
      end
   end

   // Next pipeline register value: bubble on flush or stall.
   always_comb begin
      id_to_ex_d = dec;
      if (bus.flush || hazard) begin
         id_to_ex_d = '0;
      end else begin
         id_to_ex_d = dec;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk) begin
      if (reset) begin
         id_to_ex_q <= '0;
      end else begin
         id_to_ex_q <= id_to_ex_d;
      end
   end

   assign bus.ID_to_EX = id_to_ex_q;
   assign bus.stall_if = hazard && !bus.flush && !reset;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
   import decode_stage_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   decode_stage_if bus_if ();

   decode_stage #(.NUM_REGS(32), .XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      bus_if.IF_to_ID.instruction = ins;
      bus_if.IF_to_ID.pc_cur      = pc;
   endtask

   task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
      bus_if.WB_to_ID.reg_write = we;
      bus_if.WB_to_ID.rd        = rd;
      bus_if.WB_to_ID.rd_data   = d;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      bus_if.flush = 1'b0;
      drive(32'h0000_0000, 32'h0000_0000);
      wb(1'b0, 5'd0, 32'h0);
      step();
      step();
      check_value("rst_id_to_ex_zero", 32'(bus_if.ID_to_EX == '0), 32'd1);
      check_value("rst_stall", 32'(bus_if.stall_if), 32'd0);

      // addi x1,x0,5
      reset = 1'b0;
      drive(32'h0050_0093, 32'h0000_0000);
      step();
      check_value("addi_valid", 32'(bus_if.ID_to_EX.valid), 32'd1);
      check_value("addi_rd", 32'(bus_if.ID_to_EX.rd), 32'd1);
      check_value("addi_rs1_data", bus_if.ID_to_EX.rs1_data, 32'd0);
      check_value("addi_imm", bus_if.ID_to_EX.imm_ext, 32'd5);
      check_value("addi_alu_src_imm", 32'(bus_if.ID_to_EX.alu_src_imm), 32'd1);
      check_value("addi_reg_write", 32'(bus_if.ID_to_EX.reg_write), 32'd1);
      check_value("addi_illegal", 32'(bus_if.ID_to_EX.illegal), 32'd0);

      // WB bypass: write x2 while add x2,x2,x0 is decoded
      wb(1'b1, 5'd2, 32'hDEAD_BEEF);
      drive(32'h0001_0133, 32'h0000_0004);
      step();
      check_value("bypass_rs1", bus_if.ID_to_EX.rs1_data, 32'hDEAD_BEEF);
      check_value("bypass_rs2_x0", bus_if.ID_to_EX.rs2_data, 32'd0);
      // committed value read back: add x3,x2,x2
      wb(1'b0, 5'd0, 32'h0);
      drive(32'h0021_01B3, 32'h0000_0008);
      step();
      check_value("rf_rs1_commit", bus_if.ID_to_EX.rs1_data, 32'hDEAD_BEEF);
      check_value("rf_rs2_commit", bus_if.ID_to_EX.rs2_data, 32'hDEAD_BEEF);
      check_value("pc_pass", bus_if.ID_to_EX.pc_cur, 32'h0000_0008);
      // write to x0 is ignored, bypass too
      wb(1'b1, 5'd0, 32'h1234_5678);
      drive(32'h0000_0133, 32'h0000_000C);
      step();
      check_value("x0_bypass", bus_if.ID_to_EX.rs1_data, 32'd0);
      wb(1'b0, 5'd0, 32'h0);
      step();
      check_value("x0_read", bus_if.ID_to_EX.rs1_data, 32'd0);

      // Load-use hazard: lw x5,0(x1) then add x6,x5,x0
      drive(32'h0000_A283, 32'h0000_0010);
      step();
      check_value("lw_mem_read", 32'(bus_if.ID_to_EX.mem_read), 32'd1);
      check_value("lw_result_src", 32'(bus_if.ID_to_EX.result_src), 32'd1);
      drive(32'h0002_8333, 32'h0000_0014);
      #1;
      check_value("lu_stall", 32'(bus_if.stall_if), 32'd1);
      step();
      check_value("lu_bubble_valid", 32'(bus_if.ID_to_EX.valid), 32'd0);
      check_value("lu_bubble_regwr", 32'(bus_if.ID_to_EX.reg_write), 32'd0);
      check_value("lu_stall_released", 32'(bus_if.stall_if), 32'd0);
      step();
      check_value("lu_add_valid", 32'(bus_if.ID_to_EX.valid), 32'd1);
      check_value("lu_add_rd", 32'(bus_if.ID_to_EX.rd), 32'd6);
      check_value("lu_no_stall_after", 32'(bus_if.stall_if), 32'd0);

      // Control: lw x0,0(x1) then add x6,x0,x0 -> no stall
      drive(32'h0000_A003, 32'h0000_0018);
      step();
      drive(32'h0000_0333, 32'h0000_001C);
      #1;
      check_value("ctl_no_stall", 32'(bus_if.stall_if), 32'd0);
      step();
      check_value("ctl_valid", 32'(bus_if.ID_to_EX.valid), 32'd1);

      // Immediates
      drive(32'hFE00_0EE3, 32'h0000_0020);
      step();
      check_value("beq_imm", bus_if.ID_to_EX.imm_ext, 32'hFFFF_FFFC);
      check_value("beq_branch", 32'(bus_if.ID_to_EX.branch), 32'd1);
      check_value("beq_regwr", 32'(bus_if.ID_to_EX.reg_write), 32'd0);
      drive(32'h0010_00EF, 32'h0000_0100);
      step();
      check_value("jal_imm", bus_if.ID_to_EX.imm_ext, 32'h0000_0800);
      check_value("jal_jump", 32'(bus_if.ID_to_EX.jump), 32'd1);
      check_value("jal_result_src", 32'(bus_if.ID_to_EX.result_src), 32'd2);
      check_value("jal_pc", bus_if.ID_to_EX.pc_cur, 32'h0000_0100);
      drive(32'hFE20_AC23, 32'h0000_0104);   // sw x2,-8(x1)
      step();
      check_value("sw_imm", bus_if.ID_to_EX.imm_ext, 32'hFFFF_FFF8);
      check_value("sw_mem_write", 32'(bus_if.ID_to_EX.mem_write), 32'd1);
      drive(32'h1234_50B7, 32'h0000_0108);   // lui x1,0x12345
      step();
      check_value("lui_imm", bus_if.ID_to_EX.imm_ext, 32'h1234_5000);

      // Flush over stall, with a simultaneous WB write
      drive(32'h0000_A283, 32'h0000_0200);
      step();
      drive(32'h0002_8333, 32'h0000_0204);
      bus_if.flush = 1'b1;
      wb(1'b1, 5'd7, 32'hA5A5_A5A5);
      #1;
      check_value("flush_stall", 32'(bus_if.stall_if), 32'd0);
      step();
      check_value("flush_bubble", 32'(bus_if.ID_to_EX.valid), 32'd0);
      bus_if.flush = 1'b0;
      wb(1'b0, 5'd0, 32'h0);
      drive(32'h0003_8433, 32'h0000_0208);   // add x8,x7,x0
      step();
      check_value("flush_wb_commit", bus_if.ID_to_EX.rs1_data, 32'hA5A5_A5A5);

      // Illegal encoding
      drive(32'hFFFF_FFFF, 32'h0000_0300);
      step();
      check_value("ill_illegal", 32'(bus_if.ID_to_EX.illegal), 32'd1);
      check_value("ill_valid", 32'(bus_if.ID_to_EX.valid), 32'd1);
      check_value("ill_ctrl", {27'd0, bus_if.ID_to_EX.reg_write, bus_if.ID_to_EX.mem_read,
                   bus_if.ID_to_EX.mem_write, bus_if.ID_to_EX.branch,
                   bus_if.ID_to_EX.jump}, 32'd0);

      // Reset asserted mid-stall
      drive(32'h0000_A283, 32'h0000_0400);
      step();
      drive(32'h0002_8333, 32'h0000_0404);
      #1;
      check_value("mid_stall_pre", 32'(bus_if.stall_if), 32'd1);
      reset = 1'b1;
      #1;
      check_value("mid_stall_reset", 32'(bus_if.stall_if), 32'd0);
      step();
      check_value("mid_reset_zero", 32'(bus_if.ID_to_EX == '0), 32'd1);
      reset = 1'b0;
      drive(32'h0021_01B3, 32'h0000_0408);   // add x3,x2,x2 after reset
      step();
      check_value("rf_cleared", bus_if.ID_to_EX.rs1_data, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
